// File: rtl/btb_maint_if.sv
// BTB maintenance bus: resolved-branch update in, BTB write port out.
interface btb_maint_if #(
  parameter int XLEN            = 32,
  parameter int LOG_NUM_ENTRIES = 10
);
  logic                       executing_branch_active;
  logic [LOG_NUM_ENTRIES-1:0] executing_branch_index;
  logic [2*XLEN-1:0]          executing_branch_entry;
  logic                       btb_write_en;
  logic [LOG_NUM_ENTRIES-1:0] btb_write_index;
  logic [2*XLEN-1:0]          btb_write_entry;
  logic                       btb_write_valid;

  modport master (
    output executing_branch_active,
    output executing_branch_index,
    output executing_branch_entry,
    input  btb_write_en,
    input  btb_write_index,
    input  btb_write_entry,
    input  btb_write_valid
  );

  modport slave (
    input  executing_branch_active,
    input  executing_branch_index,
    input  executing_branch_entry,
    output btb_write_en,
    output btb_write_index,
    output btb_write_entry,
    output btb_write_valid
  );
endinterface

// File: rtl/btb_maint_controller.sv
// BTB maintenance: branch updates plus a full-table invalidate walk.
// Define BTB_FLUSH_ON_RESET_EN to start a walk straight out of reset.
module btb_maint_controller #(
  parameter int XLEN            = 32,
  parameter int LOG_NUM_ENTRIES = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush_request,
  btb_maint_if.slave  bus,
  output logic        flush_busy,
  output logic [15:0] dropped_update_count
);
  typedef enum logic {IDLE, FLUSH} state_t;

`ifdef BTB_FLUSH_ON_RESET_EN
  localparam state_t RESET_STATE = FLUSH;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t                     state;
  logic [LOG_NUM_ENTRIES-1:0] flush_index;
  logic                       update;
  logic                       flushing;
  logic                       writing;

  assign update   = bus.executing_branch_active & enable;
  assign flushing = !reset && (state == FLUSH);
  assign writing  = !reset && (state == IDLE) && update;

  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= RESET_STATE;
      flush_busy           <= (RESET_STATE == FLUSH);
      flush_index          <= '0;
      dropped_update_count <= '0;
    end else begin
      if (state == FLUSH && update &&
          dropped_update_count != 16'hFFFF)
        dropped_update_count <= dropped_update_count + 16'd1;
      unique case (state)
        IDLE: begin
          if (flush_request) begin
            state       <= FLUSH;
            flush_busy  <= 1'b1;
            flush_index <= '0;
          end
        end
        FLUSH: begin
          // A new request restarts the walk from entry 0.
          if (flush_request) begin
            flush_index <= '0;
          end else if (&flush_index) begin
            state       <= IDLE;
            flush_busy  <= 1'b0;
            flush_index <= '0;
          end else begin
            flush_index <= flush_index + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.btb_write_en    = 1'b0;
    bus.btb_write_index = '0;
    bus.btb_write_entry = '0;
    bus.btb_write_valid = 1'b0;
    unique case (1'b1)
      flushing: begin
        bus.btb_write_en    = 1'b1;
        bus.btb_write_index = flush_index;
      end
      writing: begin
        bus.btb_write_en    = 1'b1;
        bus.btb_write_index = bus.executing_branch_index;
        bus.btb_write_entry = bus.executing_branch_entry;
        bus.btb_write_valid = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_btb_maint_controller.sv
// Randomized + directed check of btb_maint_controller against a walk-queue model.
module tb_btb_maint_controller;
  localparam int XLEN = 32;
  localparam int L    = 3;
  localparam int N    = 8;
  localparam int EW   = 2 * XLEN;

`ifdef BTB_FLUSH_ON_RESET_EN
  localparam bit FOR_EN = 1'b1;
`else
  localparam bit FOR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        flush_request;
  logic        flush_busy;
  logic [15:0] dropped_update_count;

  always #5 clock = ~clock;

  btb_maint_if #(.XLEN(XLEN), .LOG_NUM_ENTRIES(L)) bus ();

  btb_maint_controller #(.XLEN(XLEN), .LOG_NUM_ENTRIES(L)) dut (
    .clock                (clock),
    .reset                (reset),
    .enable               (enable),
    .flush_request        (flush_request),
    .bus                  (bus),
    .flush_busy           (flush_busy),
    .dropped_update_count (dropped_update_count)
  );

  int total = 0;
  int bad   = 0;

  // Model: indices still to be erased, in order, plus the drop count.
  int walk[$];
  int drops    = 0;
  bit model_ok = 0;

  logic          obs_en;
  logic [L-1:0]  obs_idx;
  logic [EW-1:0] obs_entry;
  logic          obs_valid;
  logic          obs_busy;
  logic [15:0]   obs_drop;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit fr, input bit en,
                      input bit act, input logic [L-1:0] idx,
                      input logic [EW-1:0] ent);
    bit upd;
    bit exp_en;
    @(negedge clock);
    reset                       = rst;
    flush_request               = fr;
    enable                      = en;
    bus.executing_branch_active = act;
    bus.executing_branch_index  = idx;
    bus.executing_branch_entry  = ent;
    #1;
    obs_en    = bus.btb_write_en;
    obs_idx   = bus.btb_write_index;
    obs_entry = bus.btb_write_entry;
    obs_valid = bus.btb_write_valid;
    obs_busy  = flush_busy;
    obs_drop  = dropped_update_count;
    upd    = act && en;
    exp_en = !rst && (walk.size() > 0 || upd);
    if (rst || model_ok) begin
      chk("write_en", {63'd0, obs_en}, {63'd0, exp_en});
      if (exp_en && walk.size() > 0) begin
        chk("flush_idx", {61'd0, obs_idx}, 64'(walk[0]));
        chk("flush_valid", {63'd0, obs_valid}, 64'd0);
        chk("flush_entry", obs_entry, 64'd0);
      end else if (exp_en) begin
        chk("upd_idx", {61'd0, obs_idx}, {61'd0, idx});
        chk("upd_valid", {63'd0, obs_valid}, 64'd1);
        chk("upd_entry", obs_entry, ent);
      end
    end
    if (model_ok) begin
      chk("busy", {63'd0, obs_busy}, 64'(walk.size() > 0));
      chk("drops", {48'd0, obs_drop}, 64'(drops));
    end
    @(posedge clock);
    if (rst) begin
      walk.delete();
      if (FOR_EN) for (int i = 0; i < N; i++) walk.push_back(i);
      drops    = 0;
      model_ok = 1;
    end else begin
      if (walk.size() > 0) begin
        if (upd && drops < 65535) drops++;
        void'(walk.pop_front());
      end
      if (fr) begin
        walk.delete();
        for (int i = 0; i < N; i++) walk.push_back(i);
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < N + 2; i++) idle();
  endtask

  initial begin
    step(1, 0, 0, 0, '0, '0);
    step(1, 0, 1, 1, 3'd2, 64'h1);
    chk("rst_en", {63'd0, obs_en}, 64'd0);
    idle();
    chk("rst_busy", {63'd0, obs_busy}, {63'd0, FOR_EN});
    chk("rst_drop", {48'd0, obs_drop}, 64'd0);
    drain();

    step(0, 1, 0, 0, '0, '0);
    chk("pre_busy", {63'd0, obs_busy}, 64'd0);
    for (int i = 0; i < N; i++) begin
      idle();
      chk("walk_en", {63'd0, obs_en}, 64'd1);
      chk("walk_idx", {61'd0, obs_idx}, 64'(i));
      chk("walk_valid", {63'd0, obs_valid}, 64'd0);
    end
    idle();
    chk("walk_done_busy", {63'd0, obs_busy}, 64'd0);
    chk("walk_done_en", {63'd0, obs_en}, 64'd0);

    step(0, 0, 1, 1, 3'd5, 64'hABCD_1234_5678_9ABC);
    chk("upd5_en", {63'd0, obs_en}, 64'd1);
    chk("upd5_idx", {61'd0, obs_idx}, 64'd5);
    chk("upd5_valid", {63'd0, obs_valid}, 64'd1);
    chk("upd5_entry", obs_entry, 64'hABCD_1234_5678_9ABC);

    step(0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 3'd6, 64'h55);
    for (int i = 3; i < N; i++) idle();
    idle();
    chk("drop3", {48'd0, obs_drop}, 64'd3);

    step(0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) idle();
    step(0, 1, 0, 0, '0, '0);
    chk("restart_at4_idx", {61'd0, obs_idx}, 64'd4);
    for (int i = 0; i < N; i++) begin
      idle();
      chk("restart_idx", {61'd0, obs_idx}, 64'(i));
      chk("restart_busy", {63'd0, obs_busy}, 64'd1);
    end
    idle();
    chk("restart_done", {63'd0, obs_busy}, 64'd0);

    step(0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) idle();
    step(1, 0, 0, 0, '0, '0);
    chk("midrst_en", {63'd0, obs_en}, 64'd0);
    idle();
    chk("midrst_en2", {63'd0, obs_en}, {63'd0, FOR_EN});
    chk("midrst_busy", {63'd0, obs_busy}, {63'd0, FOR_EN});
    if (FOR_EN) chk("midrst_idx", {61'd0, obs_idx}, 64'd0);
    drain();

    step(0, 0, 0, 1, 3'd2, 64'h77);
    chk("noen_en", {63'd0, obs_en}, 64'd0);
    idle();
    chk("noen_drop", {48'd0, obs_drop}, 64'd0);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
           1'($urandom), 1'($urandom), 3'($urandom),
           {$urandom, $urandom});
    end

    step(1, 0, 0, 0, '0, '0);
    drain();
    for (int i = 0; i < 65545; i++)
      step(0, 1, 1, 1, 3'($urandom), {$urandom, $urandom});
    drain();
    chk("sat_drop", {48'd0, obs_drop}, 64'hFFFF);
    step(0, 1, 0, 0, '0, '0);
    step(0, 0, 1, 1, 3'd1, 64'h9);
    idle();
    chk("sat_hold", {48'd0, obs_drop}, 64'hFFFF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
